// File: rtl/chk_pkg.sv
// Shared types for the CPU trace checker: instruction classes, mismatch
// record layout and the FIFO pointer-width helper.
package chk_pkg;

    typedef enum logic [2:0] {
        CLS_ADD    = 3'd0,
        CLS_SUB    = 3'd1,
        CLS_AND    = 3'd2,
        CLS_OR     = 3'd3,
        CLS_SLT    = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6,
        CLS_LOAD   = 3'd7
    } chk_class_e;

    typedef struct packed {
        logic [31:0] pc;
        chk_class_e  cls;
        logic [31:0] exp;
        logic [31:0] got;
    } chk_rec_t;

    // One extra bit beyond the address so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ccheck.sv
// CPU tap bundle: values observed on the retiring instruction. The CPU drives
// it through S, the checker samples it through M.
interface ccheck;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] rd_value;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic [31:0] lw_data;

    modport M (input rs_value, rt_value, rd_value, branch_addr, jump_addr, lw_data);
    modport S (output rs_value, rt_value, rd_value, branch_addr, jump_addr, lw_data);
endinterface

// File: rtl/chk_err_fifo.sv
// Synchronous FIFO of mismatch records with a valid/ready read side.
// A push into a full FIFO succeeds only when the head is popped in the same cycle.
module chk_err_fifo
    import chk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  chk_rec_t push_rec,
    output logic     full,
    output logic     out_valid,
    input  logic     out_ready,
    output chk_rec_t out_rec
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    chk_rec_t      mem [DEPTH];
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push && (!full || do_pop);

    // Empty FIFO presents zeros so the outputs read 0 after reset.
    assign out_rec   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define what is valid,
    // which keeps the array a plain RAM-style write port.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Checker side of the CPU tap: captures each retired instruction, recomputes
// its expected result, counts pass/fail and queues mismatch records.
module cpu_trace_checker
    import chk_pkg::*;
#(
    parameter int ERR_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ccheck.M                 chk,
    input  logic             in_valid,
    input  logic [2:0]       in_class,
    input  logic [31:0]      in_pc,
    input  logic [25:0]      in_imm,
    input  logic [31:0]      in_exp_lw,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [31:0]      err_pc,
    output logic [2:0]       err_class,
    output logic [31:0]      err_exp,
    output logic [31:0]      err_got,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             overflow
);

    // Stage 1: captured tap
    logic        s1_valid;
    chk_class_e  s1_cls;
    logic [31:0] s1_pc;
    logic [25:0] s1_imm;
    logic [31:0] s1_rs;
    logic [31:0] s1_rt;
    logic [31:0] s1_rd;
    logic [31:0] s1_ba;
    logic [31:0] s1_ja;
    logic [31:0] s1_lw;
    logic [31:0] s1_exp_lw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_cls    <= CLS_ADD;
            s1_pc     <= '0;
            s1_imm    <= '0;
            s1_rs     <= '0;
            s1_rt     <= '0;
            s1_rd     <= '0;
            s1_ba     <= '0;
            s1_ja     <= '0;
            s1_lw     <= '0;
            s1_exp_lw <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cls    <= chk_class_e'(in_class);
                s1_pc     <= in_pc;
                s1_imm    <= in_imm;
                s1_rs     <= chk.rs_value;
                s1_rt     <= chk.rt_value;
                s1_rd     <= chk.rd_value;
                s1_ba     <= chk.branch_addr;
                s1_ja     <= chk.jump_addr;
                s1_lw     <= chk.lw_data;
                s1_exp_lw <= in_exp_lw;
            end
        end
    end

    // Stage 2: expected-value mux and compare
    logic [31:0] exp_val;
    logic [31:0] got_val;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic        known_cls;
    logic        mismatch;
    logic        match;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        exp_val    = '0;
        got_val    = s1_rd;
        known_cls  = 1'b1;
        pc_plus4   = s1_pc + 32'd4;
        branch_off = {{14{s1_imm[15]}}, s1_imm[15:0], 2'b00};
        case (s1_cls)
            CLS_ADD:    exp_val = s1_rs + s1_rt;
            CLS_SUB:    exp_val = s1_rs - s1_rt;
            CLS_AND:    exp_val = s1_rs & s1_rt;
            CLS_OR:     exp_val = s1_rs | s1_rt;
            CLS_SLT:    exp_val = {31'b0, $signed(s1_rs) < $signed(s1_rt)};
            CLS_BRANCH: begin
                exp_val = pc_plus4 + branch_off;
                got_val = s1_ba;
            end
            CLS_JUMP: begin
                exp_val = {pc_plus4[31:28], s1_imm, 2'b00};
                got_val = s1_ja;
            end
            CLS_LOAD: begin
                exp_val = s1_exp_lw;
                got_val = s1_lw;
            end
            default:    known_cls = 1'b0;
        endcase
    end

    assign mismatch = s1_valid && (!known_cls || (exp_val != got_val));
    assign match    = s1_valid && !mismatch;

    // Mismatch record queue
    chk_rec_t push_rec;
    chk_rec_t head_rec;
    logic     fifo_full;
    logic     pop;

    assign push_rec = '{pc: s1_pc, cls: s1_cls, exp: exp_val, got: got_val};
    assign pop      = err_valid && err_ready;

    chk_err_fifo #(.DEPTH(ERR_DEPTH)) u_err_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mismatch),
        .push_rec  (push_rec),
        .full      (fifo_full),
        .out_valid (err_valid),
        .out_ready (err_ready),
        .out_rec   (head_rec)
    );

    assign err_pc    = head_rec.pc;
    assign err_class = head_rec.cls;
    assign err_exp   = head_rec.exp;
    assign err_got   = head_rec.got;

    // Saturating counters and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (match && (pass_cnt != {CNT_W{1'b1}}))
                pass_cnt <= pass_cnt + CNT_W'(1);
            if (mismatch && (fail_cnt != {CNT_W{1'b1}}))
                fail_cnt <= fail_cnt + CNT_W'(1);
            if (mismatch && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule
